// File: rtl/wb_stage.sv
// Writeback stage: merges the ALU result stream with FIFO-buffered load results onto the
// register-file write port. Optional WAW kill logic is compiled in with WB_WAW_KILL_EN.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_rd_addr,
    output logic [XLEN-1:0]          rf_w_data,
    output logic                     fwd_valid,
    output logic [4:0]               fwd_rd,
    output logic [XLEN-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]   lsu_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] ent_valid_q, ent_valid_d;
    logic [4:0]      ent_rd_q   [DEPTH];
    logic [4:0]      ent_rd_d   [DEPTH];
    logic [XLEN-1:0] ent_data_q [DEPTH];
    logic [XLEN-1:0] ent_data_d [DEPTH];

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_addr_q, rf_rd_addr_d;
    logic [XLEN-1:0] rf_w_data_q, rf_w_data_d;

    logic            push, pop, fifo_empty, push_valid;
    logic            head_valid;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
`ifdef WB_WAW_KILL_EN
    logic            kill_en;
`endif

    assign lsu_ready = (count_q != FULL_CNT);

    always_comb begin
        fifo_empty = (count_q == '0);
        push       = lsu_valid && lsu_ready;
        pop        = !alu_valid && (!fifo_empty || push);

`ifdef WB_WAW_KILL_EN
        // A younger ALU write to the same rd makes any pending load for it dead.
        kill_en    = alu_valid && (alu_rd != 5'd0);
        push_valid = !(kill_en && (lsu_rd == alu_rd));
`else
        push_valid = 1'b1;
`endif

        // With an empty FIFO the incoming load bypasses storage.
        if (fifo_empty) begin
            head_valid = push_valid;
            head_rd    = lsu_rd;
            head_data  = lsu_data;
        end else begin
            head_valid = ent_valid_q[rd_ptr_q];
            head_rd    = ent_rd_q[rd_ptr_q];
            head_data  = ent_data_q[rd_ptr_q];
        end

        ent_valid_d = ent_valid_q;
        ent_rd_d    = ent_rd_q;
        ent_data_d  = ent_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

`ifdef WB_WAW_KILL_EN
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (ent_rd_q[i] == alu_rd)) begin
                ent_valid_d[i] = 1'b0;
            end
        end
`endif

        if (push) begin
            ent_valid_d[wr_ptr_q] = push_valid;
            ent_rd_d[wr_ptr_q]    = lsu_rd;
            ent_data_d[wr_ptr_q]  = lsu_data;
            wr_ptr_d              = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        rf_we_d      = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_w_data_d  = rf_w_data_q;
        if (alu_valid) begin
            rf_we_d      = (alu_rd != 5'd0);
            rf_rd_addr_d = alu_rd;
            rf_w_data_d  = alu_data;
        end else if (pop) begin
            rf_we_d      = head_valid && (head_rd != 5'd0);
            rf_rd_addr_d = head_rd;
            rf_w_data_d  = head_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ent_valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_rd_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            rf_we_q      <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_w_data_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ent_valid_q  <= ent_valid_d;
            ent_rd_q     <= ent_rd_d;
            ent_data_q   <= ent_data_d;
            rf_we_q      <= rf_we_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_w_data_q  <= rf_w_data_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign rf_w_data  = rf_w_data_q;
    assign fwd_valid  = rf_we_q;
    assign fwd_rd     = rf_rd_addr_q;
    assign fwd_data   = rf_w_data_q;
    assign lsu_count  = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-cycle vector table with a scoreboard of expected
// writes, plus a hand-written asynchronous mid-stream reset sequence.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_w_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [1:0]  lsu_count;

    int tests_run = 0;
    int tests_failed = 0;

    wb_stage #(.XLEN(32), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_we      (rf_we),
        .rf_rd_addr (rf_rd_addr),
        .rf_w_data  (rf_w_data),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .lsu_count  (lsu_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        ready;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  cnt;
        logic        chk_ad;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  cnt;
        logic        chk_ad;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adat,
                                logic lv, logic [4:0] lrd, logic [31:0] ldat,
                                logic ready, logic we, logic [4:0] rd, logic [31:0] data,
                                logic [1:0] cnt, logic chk_ad);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.ready = ready; v.we = we; v.rd = rd; v.data = data;
        v.cnt = cnt; v.chk_ad = chk_ad;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, then compare after the edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
        #1;
        checkOutput("lsu_ready", 32'(lsu_ready), 32'(v.ready));
        e.we = v.we; e.rd = v.rd; e.data = v.data; e.cnt = v.cnt; e.chk_ad = v.chk_ad;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard: empty queue at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            checkOutput("rf_we", 32'(rf_we), 32'(e.we));
            checkOutput("fwd_valid", 32'(fwd_valid), 32'(e.we));
            checkOutput("lsu_count", 32'(lsu_count), 32'(e.cnt));
            if (e.we || e.chk_ad) begin
                checkOutput("rf_rd_addr", 32'(rf_rd_addr), 32'(e.rd));
                checkOutput("rf_w_data", rf_w_data, e.data);
                checkOutput("fwd_rd", 32'(fwd_rd), 32'(e.rd));
                checkOutput("fwd_data", fwd_data, e.data);
            end
        end
    endtask

    initial begin
        logic kill_on;
`ifdef WB_WAW_KILL_EN
        kill_on = 1'b1;
`else
        kill_on = 1'b0;
`endif
        reset = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

        //                av  ard    adat        lv  lrd    ldat         rdy we  rd     data        cnt chk
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1,  0, 5'd0,  32'h0,      0,  1));
        vecs.push_back(mk(1, 5'd5,  32'h1234,   0, 5'd0,  32'h0,       1,  1, 5'd5,  32'h1234,   0,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1,  0, 5'd0,  32'h0,      0,  0));
        vecs.push_back(mk(1, 5'd3,  32'h5,      1, 5'd7,  32'hAAAA,    1,  1, 5'd3,  32'h5,      1,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1,  1, 5'd7,  32'hAAAA,   0,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      1, 5'd8,  32'hBEEF,    1,  1, 5'd8,  32'hBEEF,   0,  0));
        vecs.push_back(mk(1, 5'd1,  32'hA1,     1, 5'd10, 32'h100,     1,  1, 5'd1,  32'hA1,     1,  0));
        vecs.push_back(mk(1, 5'd2,  32'hA2,     1, 5'd11, 32'h200,     1,  1, 5'd2,  32'hA2,     2,  0));
        vecs.push_back(mk(1, 5'd3,  32'hA3,     1, 5'd12, 32'h300,     0,  1, 5'd3,  32'hA3,     2,  0));
        vecs.push_back(mk(1, 5'd4,  32'hA4,     1, 5'd12, 32'h300,     0,  1, 5'd4,  32'hA4,     2,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      1, 5'd12, 32'h300,     0,  1, 5'd10, 32'h100,    1,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      1, 5'd12, 32'h300,     1,  1, 5'd11, 32'h200,    1,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1,  1, 5'd12, 32'h300,    0,  0));
        vecs.push_back(mk(1, 5'd0,  32'hFFFF,   0, 5'd0,  32'h0,       1,  0, 5'd0,  32'hFFFF,   0,  1));
        vecs.push_back(mk(0, 5'd0,  32'h0,      1, 5'd0,  32'h77,      1,  0, 5'd0,  32'h77,     0,  1));
        vecs.push_back(mk(1, 5'd2,  32'h1,      1, 5'd9,  32'h11,      1,  1, 5'd2,  32'h1,      1,  0));
        vecs.push_back(mk(1, 5'd9,  32'h22,     0, 5'd0,  32'h0,       1,  1, 5'd9,  32'h22,     1,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1, !kill_on, 5'd9, 32'h11, 0, 1));
        vecs.push_back(mk(1, 5'd6,  32'h66,     1, 5'd6,  32'h60,      1,  1, 5'd6,  32'h66,     1,  0));
        vecs.push_back(mk(0, 5'd0,  32'h0,      0, 5'd0,  32'h0,       1, !kill_on, 5'd6, 32'h60, 0, 1));
        vecs.push_back(mk(1, 5'd13, 32'h13,     1, 5'd14, 32'h14,      1,  1, 5'd13, 32'h13,     1,  0));
        vecs.push_back(mk(1, 5'd15, 32'h15,     1, 5'd16, 32'h16,      1,  1, 5'd15, 32'h15,     2,  0));

        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Asynchronous reset between edges with two loads queued.
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        checkOutput("rst_fwd_rd", 32'(fwd_rd), 32'd0);
        checkOutput("rst_fwd_data", fwd_data, 32'd0);
        checkOutput("rst_lsu_count", 32'(lsu_count), 32'd0);
        checkOutput("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_rf_we", 32'(rf_we), 32'd0);
            checkOutput("post_rst_count", 32'(lsu_count), 32'd0);
        end
        checkOutput("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that sits directly upstream of the integer register file and owns its single write port (we / rd_addr / w_data). It merges the single-cycle ALU result stream, which has priority and can never stall, with long-latency load results, which arrive on a valid/ready handshake and are buffered in a small FIFO. The registered write is also exported as a forwarding bus for the execute stage.

## Interface
- XLEN, 32: data width.
- DEPTH, 2: load-result FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result valid this cycle; no ready, always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  load result valid.
- lsu_ready  out  1  FIFO can accept; equals (count != DEPTH), registered-state only.
- lsu_rd  in  5  load destination register.
- lsu_data  in  XLEN  load data.
- rf_we  out  1  register-file write enable, registered.
- rf_rd_addr  out  5  register-file destination, registered.
- rf_w_data  out  XLEN  register-file write data, registered.
- fwd_valid  out  1  equals rf_we; forwarding qualifier.
- fwd_rd  out  5  equals rf_rd_addr.
- fwd_data  out  XLEN  equals rf_w_data.
- lsu_count  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Load accept: lsu_valid && lsu_ready pushes {valid=1, rd, data} at the tail.
- Per cycle, select the output source:
  - If alu_valid, the ALU result drives the output register.
  - Otherwise, if the FIFO is non-empty, pop the head and drive the output register with it.
  - Otherwise nothing is driven and rf_we = 0.
- Empty-FIFO fast path: a load pushed in cycle N with the FIFO empty and alu_valid low in N is popped in the same cycle N.
- rd = 0: the slot is consumed, but rf_we = 0 and rf_rd_addr/rf_w_data carry the values with we low. This applies to both sources.
- Popping a killed entry (valid=0) also produces rf_we = 0 for that slot.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count tracks pushes and pops:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full: lsu_ready = 0, so no push. A pop in that cycle frees a slot, visible the next cycle; there is no same-cycle pass-through when full.
- Reset (asynchronous, any time) clears:
  - pointers and count to 0;
  - all entry valid bits;
  - rf_we, rf_rd_addr and rf_w_data to 0.
- Consequently lsu_ready = 1 and fwd_* = 0 during and after reset. In-flight loads are discarded.

## Timing
- Latency: input sampled at edge N → rf_we/rf_rd_addr/rf_w_data valid from edge N+1 for exactly one cycle. The register file commits at edge N+2.
- A load stalled behind ALU traffic waits one cycle per consecutive alu_valid cycle. There is no starvation guarantee; upstream must leave bubbles.
- lsu_ready depends only on registered count, with no combinational path from any input.
- Push and pop in the same cycle at count = 1: the head is popped and the new entry becomes head; count stays 1.

## Configuration
- WB_WAW_KILL_EN defined: the WAW kill logic is compiled in.
  - When alu_valid with alu_rd != 0, every queued entry whose rd == alu_rd has its valid bit cleared at that edge.
  - A load pushed in the same cycle with lsu_rd == alu_rd is also pushed with valid = 0, because the load is older in program order.
  - Killed entries still occupy a slot and drain with rf_we = 0.
- WB_WAW_KILL_EN undefined: no kill logic is present. Upstream guarantees that no ALU op writes an rd with a pending load, and all entries drain with valid = 1.

## Test plan
- Reset mid-stream:
  - Stimulus: FIFO holds 2 loads; assert reset asynchronously between edges.
  - Response: rf_we = 0 and lsu_count = 0 immediately, lsu_ready = 1; no writes after release.
- ALU only:
  - Stimulus: alu_valid with rd = 5, data = 0x1234 at edge N.
  - Response: rf_we = 1, rf_rd_addr = 5, rf_w_data = 0x1234, fwd_* identical, all at N+1; rf_we = 0 at N+2.
- Collision and drain:
  - Stimulus: load rd = 7, data 0xAAAA and ALU rd = 3, data 0x5 in the same cycle N.
  - Response: ALU write at N+1, load write at N+2; lsu_count = 1 for the one cycle after N.
- Full back-pressure:
  - Stimulus: alu_valid held high for 4 cycles while offering 3 loads, DEPTH = 2.
  - Response: first two accepted; lsu_ready = 0 after the second push; third accepted only after the first pop. All three later written in order.
- rd = 0:
  - Stimulus: ALU rd = 0, data 0xFFFF, then load rd = 0.
  - Response: both slots consumed, rf_we = 0 throughout; load handshake completes.
- WAW kill, with WB_WAW_KILL_EN:
  - Stimulus: queue load rd = 9, data 0x11; then ALU rd = 9, data 0x22.
  - Response: rf_rd_addr = 9 / rf_w_data = 0x22 with rf_we = 1, then the load slot drains with rf_we = 0.
  - Without the macro: 0x22 then 0x11 are both written.
